// File: rtl/pigro_pkg.sv
// Shared definitions for the PIGRO core: instruction-phase state encodings
// and the bit positions of the one-hot phase enable vector.
// Contents: state_e enum, PH_* phase_en bit indices.
package pigro_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Bit positions within phase_en, order {WB,EXEC,DECODE,FETCH}.
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_WB     = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable tick divider: tick is a registered one-clock pulse every div+1 clocks.
// Latency: first tick registered on the (div+1)th rising edge after reset release.
// Backpressure: none; free-running. Ports: clock, reset (async high), div -> tick.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // >= rather than == so that lowering div below the running count
    // wraps on the very next clock instead of running to the top.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (cnt_q >= div) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/phase_sched.sv
// Instruction-phase scheduler: sequences FETCH/DECODE/EXEC/WB strobes on CPU ticks, run/halt/step, retire count.
// Latency: HALT->FETCH one clock after run_req; each phase lasts one tick period, +1 period per stalled tick.
// Backpressure: mem_wait on a tick in FETCH/EXEC suppresses the strobe and holds the phase. Macro: PHASE_SCHED_STEP_EN.
// Ports: clock, reset, div, run_req, step_req, mem_wait -> tick, phase_en[3:0], halted, instr_done, icount.
module phase_sched
    import pigro_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             mem_wait,
    output logic             tick,
    output logic [3:0]       phase_en,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] icount
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic             step_go;

`ifdef PHASE_SCHED_STEP_EN
    assign step_go = step_req;
`else
    logic unused_step;
    assign unused_step = step_req;
    assign step_go     = 1'b0;
`endif

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .div   (div),
        .tick  (tick)
    );

    // Strobes are combinational from registered state/tick so a stall
    // seen on the tick clock removes the strobe in that same clock.
    always_comb begin
        phase_en = '0;
        state_d  = state_q;
        unique case (state_q)
            ST_HALT: begin
                // Leaving HALT needs no tick; FETCH then waits for one.
                if (run_req || step_go) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                phase_en[PH_FETCH] = tick & ~mem_wait;
                if (phase_en[PH_FETCH]) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                phase_en[PH_DECODE] = tick;
                if (phase_en[PH_DECODE]) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                phase_en[PH_EXEC] = tick & ~mem_wait;
                if (phase_en[PH_EXEC]) state_d = ST_WB;
            end
            ST_WB: begin
                phase_en[PH_WB] = tick;
                // Halt requests only take effect at the instruction boundary.
                if (phase_en[PH_WB]) state_d = run_req ? ST_FETCH : ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign icount_d = icount_q + {{(CNT_W-1){1'b0}}, phase_en[PH_WB]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_HALT;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    assign halted     = (state_q == ST_HALT);
    assign instr_done = phase_en[PH_WB];
    assign icount     = icount_q;

endmodule

// File: doc/phase_sched.md
# phase_sched

PIGRO's instruction-phase scheduler. It divides the system clock into a programmable CPU tick and sequences the four instruction phases, FETCH, DECODE, EXEC and WB, as one-hot enable strobes to the datapath. It owns run/halt control at instruction boundaries, stalls on memory wait, and counts retired instructions. It sits between the clock generator and the core datapath.

## Interface
Parameters:
- DIV_W, 8, width of the tick divider input.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- div, input, DIV_W: tick period is div+1 clocks; 0 means a tick every clock.
- run_req, input, 1: level; 1 means run continuously, 0 means halt at the next instruction boundary.
- step_req, input, 1: pulse; execute exactly one instruction from HALT.
- mem_wait, input, 1: memory not ready; stalls the FETCH and EXEC phases.
- tick, output, 1: registered; high one clock per tick period.
- phase_en, output, 4: one-hot, bit order {WB,EXEC,DECODE,FETCH}; high only on an advancing tick.
- halted, output, 1: high while the state is HALT.
- instr_done, output, 1: one-clock pulse, identical to phase_en[3].
- icount, output, CNT_W: retired-instruction count.

## Operation
- Prescaler:
  - cnt counts from 0 up to div.
  - When cnt >= div: tick<=1 and cnt<=0. Otherwise tick<=0 and cnt<=cnt+1.
  - The >= compare makes a mid-count decrease of div wrap on the next clock.
- States: HALT, FETCH, DECODE, EXEC, WB.
- Phase enable:
  - phase_en[S] = tick & (state==S) & !(mem_wait & S∈{FETCH,EXEC}).
  - phase_en is combinational from registered state, registered tick and mem_wait.
  - The state advances only on a clock where its phase_en bit is high.
- Transitions:
  - HALT → FETCH when run_req=1, or when step_req=1 (with STEP enabled). No tick is required for this transition.
  - FETCH → DECODE → EXEC → WB, each on its own enable.
  - WB → FETCH when run_req=1. Otherwise WB → HALT.
  - A single step ends in HALT unless run_req=1.
- Halt and stall rules:
  - run_req falling mid-instruction: the instruction completes through WB, then the block halts.
  - mem_wait on a non-tick clock, or in DECODE/WB, has no effect.
  - A stall holds the phase for whole tick periods.
- Counter: icount increments on instr_done and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (asynchronous, immediate) values:
  - state=HALT, cnt=0, tick=0.
  - phase_en=0, halted=1, instr_done=0, icount=0.
- First tick: at the clock where cnt reaches div, i.e. the (div+1)th rising edge after reset release.
- Start latency: run_req sampled at edge k gives state=FETCH and halted=0 after edge k. The first phase_en[0] occurs on the first tick at or after edge k+1.
- Unstalled instruction: 4 ticks, i.e. 4·(div+1) clocks. Each stalled tick adds div+1 clocks.
- run_req and step_req both high in HALT: treated as run.
- Reset asserted mid-phase: no partial strobe. icount is cleared.

## Configuration
- PHASE_SCHED_STEP_EN defined:
  - step_req is honoured in HALT only.
  - step_req while running is ignored.
- PHASE_SCHED_STEP_EN undefined:
  - The step_req port remains but is ignored.
  - HALT is left only via run_req.

## Structure
- Shared package pigro_pkg holds:
  - The state encodings: HALT=3'd4, FETCH=0, DECODE=1, EXEC=2, WB=3.
  - The phase_en bit indices.
- Sub-module tick_prescaler (clock, reset, div → tick) holds the divider. The FSM and counter stay in phase_sched.

## Test plan
- Reset, div=0, run_req=1 from edge 1: phase_en cycles 0001,0010,0100,1000 every clock starting at edge 2. icount=3 after 12 enables.
- div=3, run_req=1: tick every 4 clocks. One instruction takes 16 clocks, and phase_en is never high without tick.
- mem_wait=1 for 2 ticks during EXEC, div=1: EXEC held 2 extra ticks (4 clocks). The DECODE and WB enables are unaffected by mem_wait.
- run_req dropped during DECODE: EXEC and WB still strobe, then halted=1. icount increments by exactly 1.
- With PHASE_SCHED_STEP_EN, run_req=0, step_req pulsed in HALT: exactly one FETCH..WB sequence, then halted=1. A pulse while running leaves icount unchanged. Without the macro, the same pulse does nothing.
- Covers three cases:
  - icount preset near wrap via force to 2^32-1: next instr_done gives icount=0.
  - reset pulsed mid-EXEC: all outputs return to reset values within the same clock.
  - div changed from 7 to 2 while cnt=5: tick on the next clock.
